// File: rtl/voice_allocator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// voice_allocator : queues note requests and hands each one to the lowest
//                   idle player voice, or to the oldest busy voice when stealing
// Rev 1.0
// ============================================================================
module voice_allocator #(
  parameter int NUM_VOICES  = 3,
  parameter int QUEUE_DEPTH = 4,
  parameter int STEAL       = 1,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              play,
  input  logic                              load_new_note,
  input  logic [5:0]                        note_to_load,
  input  logic [5:0]                        duration_to_load,
  input  logic [NUM_VOICES-1:0]             voice_playing,
  output logic [NUM_VOICES-1:0]             voice_load,
  output logic [5:0]                        note_out,
  output logic [5:0]                        duration_out,
  output logic                              queue_full,
  output logic                              dropped,
  output logic                              ack_error,
  output logic [$clog2(NUM_VOICES+1)-1:0]   active_count,
  output logic [$clog2(NUM_VOICES+1)-1:0]   mix_shift
);

  localparam int CNT_W  = $clog2(NUM_VOICES + 1);
  localparam int SEL_W  = $clog2(NUM_VOICES);
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int QCNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int TMR_W  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SELECT   = 2'd1,
    S_LOAD     = 2'd2,
    S_WAIT_ACK = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [5:0]          note_q, note_d;
  logic [5:0]          dur_q, dur_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [SEL_W-1:0]    age_q [NUM_VOICES];
  logic [SEL_W-1:0]    age_d [NUM_VOICES];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [QCNT_W-1:0]   qcount_q, qcount_d;
  logic [11:0]         fifo_mem_q [QUEUE_DEPTH];
  logic [CNT_W-1:0]    active_q, active_d;
  logic [CNT_W-1:0]    mix_q, mix_d;

  logic                push;
  logic                pop;
  logic [NUM_VOICES-1:0] reserved;
  logic                found_idle;
  logic [SEL_W-1:0]    idle_idx;
  logic                found_busy;
  logic [SEL_W-1:0]    steal_idx;
  logic [SEL_W-1:0]    best_age;
  logic [11:0]         fifo_head;

  assign queue_full   = (qcount_q == QCNT_W'(QUEUE_DEPTH));
  // A full FIFO rejects the strobe even when a pop frees a slot this cycle.
  assign push         = load_new_note && !queue_full;
  assign dropped      = load_new_note && queue_full;
  assign fifo_head    = fifo_mem_q[rd_ptr_q];
  assign note_out     = note_q;
  assign duration_out = dur_q;
  assign active_count = active_q;
  assign mix_shift    = mix_q;

  always_comb begin
    reserved = '0;
    if (state_q == S_WAIT_ACK) reserved[sel_q] = 1'b1;
  end

  // Lowest idle index wins; among busy voices the largest age wins, ties to lowest index.
  always_comb begin
    found_idle = 1'b0;
    idle_idx   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!voice_playing[i] && !reserved[i]) begin
        found_idle = 1'b1;
        idle_idx   = SEL_W'(i);
      end
    end
    found_busy = 1'b0;
    steal_idx  = '0;
    best_age   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (voice_playing[i] && !reserved[i] && (!found_busy || age_q[i] > best_age)) begin
        found_busy = 1'b1;
        steal_idx  = SEL_W'(i);
        best_age   = age_q[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    note_d    = note_q;
    dur_d     = dur_q;
    timer_d   = timer_q;
    pop       = 1'b0;
    ack_error = 1'b0;
    voice_load = '0;
    for (int i = 0; i < NUM_VOICES; i++) age_d[i] = age_q[i];

    case (state_q)
      S_IDLE: begin
        if (play && (qcount_q != '0)) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (!play) begin
          state_d = S_IDLE;
        end else if (found_idle || ((STEAL != 0) && found_busy)) begin
          pop     = 1'b1;
          sel_d   = found_idle ? idle_idx : steal_idx;
          note_d  = fifo_head[11:6];
          dur_d   = fifo_head[5:0];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        voice_load[sel_q] = 1'b1;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (SEL_W'(i) == sel_q) begin
            age_d[i] = '0;
          end else if (voice_playing[i] && (age_q[i] != SEL_W'(NUM_VOICES - 1))) begin
            age_d[i] = age_q[i] + 1'b1;
          end
        end
        timer_d = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        timer_d = timer_q + 1'b1;
        if (voice_playing[sel_q]) begin
          state_d = S_IDLE;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          ack_error = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    qcount_d = qcount_q + QCNT_W'(push) - QCNT_W'(pop);
  end

  always_comb begin
    active_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) active_d = active_d + CNT_W'(voice_playing[i]);
    mix_d = (active_d == '0) ? '0 : active_d - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {note_to_load, duration_to_load};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      note_q   <= '0;
      dur_q    <= '0;
      timer_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      qcount_q <= '0;
      active_q <= '0;
      mix_q    <= '0;
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      note_q   <= note_d;
      dur_q    <= dur_d;
      timer_q  <= timer_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      qcount_q <= qcount_d;
      active_q <= active_d;
      mix_q    <= mix_d;
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= age_d[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_voice_allocator : directed bench for voice_allocator (stealing and
//                      non-stealing instances driven side by side)
// Rev 1.0
// ============================================================================
module tb_voice_allocator;

  logic       clk = 1'b0;
  logic       reset;
  logic       play;
  logic       load_new_note;
  logic [5:0] note_to_load;
  logic [5:0] duration_to_load;
  logic [2:0] rnd_vp;
  logic [2:0] vp_q, vpn_q;
  logic       ack_en;
  logic [2:0] clr_mask;
  logic [2:0] exp_ld [4];

  logic [2:0] voice_playing, voice_load;
  logic [5:0] note_out, duration_out;
  logic       queue_full, dropped, ack_error;
  logic [1:0] active_count, mix_shift;

  logic [2:0] ns_voice_playing, ns_voice_load;
  logic [5:0] ns_note_out, ns_duration_out;
  logic       ns_queue_full, ns_dropped, ns_ack_error;
  logic [1:0] ns_active_count, ns_mix_shift;

  int total = 0;
  int bad   = 0;
  int extra;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(3), .QUEUE_DEPTH(4), .STEAL(1), .ACK_TIMEOUT(4)) u_dut (
    .clk(clk), .reset(reset), .play(play), .load_new_note(load_new_note),
    .note_to_load(note_to_load), .duration_to_load(duration_to_load),
    .voice_playing(voice_playing), .voice_load(voice_load),
    .note_out(note_out), .duration_out(duration_out),
    .queue_full(queue_full), .dropped(dropped), .ack_error(ack_error),
    .active_count(active_count), .mix_shift(mix_shift)
  );

  voice_allocator #(.NUM_VOICES(3), .QUEUE_DEPTH(4), .STEAL(0), .ACK_TIMEOUT(4)) u_dut_ns (
    .clk(clk), .reset(reset), .play(play), .load_new_note(load_new_note),
    .note_to_load(note_to_load), .duration_to_load(duration_to_load),
    .voice_playing(ns_voice_playing), .voice_load(ns_voice_load),
    .note_out(ns_note_out), .duration_out(ns_duration_out),
    .queue_full(ns_queue_full), .dropped(ns_dropped), .ack_error(ns_ack_error),
    .active_count(ns_active_count), .mix_shift(ns_mix_shift)
  );

  // Player models: a loaded voice starts playing the next cycle when ack_en is set.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      vp_q  <= 3'b000;
      vpn_q <= 3'b000;
    end else begin
      vp_q  <= (vp_q  | (ack_en ? voice_load    : 3'b000)) & ~clr_mask;
      vpn_q <= (vpn_q | (ack_en ? ns_voice_load : 3'b000)) & ~clr_mask;
    end
  end

  assign voice_playing    = reset ? vp_q  : rnd_vp;
  assign ns_voice_playing = reset ? vpn_q : rnd_vp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_load(input int lim);
    int n;
    n = 0;
    while (voice_load == 3'b000 && n < lim) begin
      tick();
      n++;
    end
    chk("wait_load", {31'd0, voice_load != 3'b000}, 32'd1);
  endtask

  initial begin
    exp_ld[0] = 3'b001;
    exp_ld[1] = 3'b010;
    exp_ld[2] = 3'b100;
    exp_ld[3] = 3'b001;
    reset = 1'b0;
    ack_en = 1'b1;
    clr_mask = 3'b000;
    play = 1'b0;
    load_new_note = 1'b0;
    note_to_load = 6'd0;
    duration_to_load = 6'd0;
    rnd_vp = 3'b000;

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      load_new_note    = 1'($urandom);
      play             = 1'($urandom);
      note_to_load     = 6'($urandom);
      duration_to_load = 6'($urandom);
      rnd_vp           = 3'($urandom);
      tick();
      chk("rst_voice_load", {29'd0, voice_load}, 32'd0);
      chk("rst_queue_full", {31'd0, queue_full}, 32'd0);
      chk("rst_active_count", {30'd0, active_count}, 32'd0);
    end
    chk("rst_ack_error", {31'd0, ack_error}, 32'd0);
    chk("rst_mix_shift", {30'd0, mix_shift}, 32'd0);

    reset = 1'b1;
    load_new_note = 1'b0;
    rnd_vp = 3'b000;
    play = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (voice_load != 3'b000) extra++;
    end
    chk("post_rst_no_load", extra, 32'd0);
    chk("post_rst_queue_full", {31'd0, queue_full}, 32'd0);

    // Single request on an idle bank: load three cycles after the strobe
    load_new_note = 1'b1; note_to_load = 6'd20; duration_to_load = 6'd8;
    tick();
    load_new_note = 1'b0;
    tick();
    chk("lat_before_load", {29'd0, voice_load}, 32'd0);
    tick();
    chk("idle_load", {29'd0, voice_load}, 32'b001);
    chk("idle_note", {26'd0, note_out}, 32'd20);
    chk("idle_dur", {26'd0, duration_out}, 32'd8);
    tick();
    chk("load_pulse_end", {29'd0, voice_load}, 32'd0);
    chk("note_hold", {26'd0, note_out}, 32'd20);
    tick();

    // Fill order with all players idle
    clr_mask = 3'b111;
    tick();
    clr_mask = 3'b000;
    for (int i = 0; i < 3; i++) begin
      load_new_note = 1'b1; note_to_load = 6'(21 + i); duration_to_load = 6'(10 + i);
      tick();
      load_new_note = 1'b0;
      tick();
      tick();
      chk("fill_load", {29'd0, voice_load}, 32'(1 << i));
      chk("fill_note", {26'd0, note_out}, 32'(21 + i));
      tick(); tick(); tick();
    end
    chk("fill_active_count", {30'd0, active_count}, 32'd3);
    chk("fill_mix_shift", {30'd0, mix_shift}, 32'd2);

    // Fourth request with every voice busy
    load_new_note = 1'b1; note_to_load = 6'd24; duration_to_load = 6'd14;
    tick();
    load_new_note = 1'b0;
    tick();
    tick();
    chk("steal_load", {29'd0, voice_load}, 32'b001);
    chk("steal_note", {26'd0, note_out}, 32'd24);
    chk("nosteal_hold", {29'd0, ns_voice_load}, 32'd0);
    tick(); tick(); tick();
    chk("nosteal_still_hold", {29'd0, ns_voice_load}, 32'd0);
    clr_mask = 3'b010;
    tick();
    clr_mask = 3'b000;
    tick();
    chk("nosteal_load", {29'd0, ns_voice_load}, 32'b010);
    chk("nosteal_note", {26'd0, ns_note_out}, 32'd24);
    tick(); tick();

    // Overflow while paused, then drain in FIFO order
    clr_mask = 3'b111;
    play = 1'b0;
    tick();
    clr_mask = 3'b000;
    for (int i = 0; i < 5; i++) begin
      load_new_note = 1'b1; note_to_load = 6'(30 + i); duration_to_load = 6'(40 + i);
      #1;
      if (i == 3) begin
        chk("ovf_not_full_yet", {31'd0, queue_full}, 32'd0);
        chk("ovf_no_drop_yet", {31'd0, dropped}, 32'd0);
      end
      if (i == 4) begin
        chk("ovf_full", {31'd0, queue_full}, 32'd1);
        chk("ovf_dropped", {31'd0, dropped}, 32'd1);
      end
      tick();
    end
    load_new_note = 1'b0;
    #1;
    chk("ovf_drop_pulse_end", {31'd0, dropped}, 32'd0);
    chk("ovf_paused_no_load", {29'd0, voice_load}, 32'd0);
    play = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_load(10);
      chk("drain_voice", {29'd0, voice_load}, {29'd0, exp_ld[k]});
      chk("drain_note", {26'd0, note_out}, 32'(30 + k));
      chk("drain_dur", {26'd0, duration_out}, 32'(40 + k));
      tick();
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (voice_load != 3'b000) extra++;
      tick();
    end
    chk("drain_no_extra", extra, 32'd0);

    // Player never acknowledges
    clr_mask = 3'b111;
    ack_en = 1'b0;
    tick();
    clr_mask = 3'b000;
    load_new_note = 1'b1; note_to_load = 6'd50; duration_to_load = 6'd5;
    tick();
    load_new_note = 1'b0;
    tick();
    tick();
    chk("to_load", {29'd0, voice_load}, 32'b001);
    tick(); tick(); tick();
    chk("to_no_err_early", {31'd0, ack_error}, 32'd0);
    tick();
    chk("to_err", {31'd0, ack_error}, 32'd1);
    tick();
    chk("to_err_end", {31'd0, ack_error}, 32'd0);
    load_new_note = 1'b1; note_to_load = 6'd51; duration_to_load = 6'd6;
    tick();
    load_new_note = 1'b0;
    tick();
    tick();
    chk("to_reload", {29'd0, voice_load}, 32'b001);
    chk("to_reload_note", {26'd0, note_out}, 32'd51);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
